// File: rtl/lru_age_tracker_pkg.sv
// Shared types and defaults for the per-set BTB LRU age tracker.
package lru_age_tracker_pkg;

   // Default geometry: eight lines per BTB set, three-bit line index / age.
   localparam int DEF_NUM_LINES  = 8;
   localparam int DEF_LINE_WIDTH = $clog2(DEF_NUM_LINES);

   // Kind of access presented on the en/hit strobes in a given cycle.
   typedef enum logic [1:0] {
      ACC_IDLE = 2'd0,
      ACC_HIT  = 2'd1,
      ACC_FILL = 2'd2
   } access_e;

   // Decode the access strobes into an access kind.
   function automatic access_e decode_access(input logic en, input logic hit);
      if (!en)
         return ACC_IDLE;
      else if (hit)
         return ACC_HIT;
      else
         return ACC_FILL;
   endfunction

endpackage

// File: rtl/lru_victim_select.sv
// Victim selection for the LRU tracker: lowest-index invalid line wins,
// otherwise the line holding the oldest age (NUM_LINES-1).
import lru_age_tracker_pkg::*;

module lru_victim_select #(
   parameter int NUM_LINES  = DEF_NUM_LINES,
   parameter int LINE_WIDTH = $clog2(NUM_LINES)
) (
   input  logic [NUM_LINES-1:0]            valid,
   input  logic [NUM_LINES*LINE_WIDTH-1:0] age_flat,
   output logic [LINE_WIDTH-1:0]           lru_line,
   output logic                            full
);

   logic [LINE_WIDTH-1:0] inv_idx;
   logic [LINE_WIDTH-1:0] old_idx;

   // Priority-encode the lowest invalid line and match the oldest age.
   always_comb begin
      full    = &valid;
      inv_idx = '0;
      old_idx = '0;
      // Scan downwards so the lowest invalid index is the last one written.
      for (int i = NUM_LINES - 1; i >= 0; i--) begin
         if (!valid[i])
            inv_idx = LINE_WIDTH'(i);
      end
      // Ages form a permutation, so exactly one line matches.
      for (int i = 0; i < NUM_LINES; i++) begin
         if (age_flat[i*LINE_WIDTH +: LINE_WIDTH] == LINE_WIDTH'(NUM_LINES - 1))
            old_idx = LINE_WIDTH'(i);
      end
      lru_line = full ? old_idx : inv_idx;
   end

endmodule

// File: rtl/lru_age_tracker.sv
// True-LRU replacement tracker for one BTB set. Each line carries an age
// rank (a permutation of 0..NUM_LINES-1, 0 = most recent) and a valid bit.
import lru_age_tracker_pkg::*;

module lru_age_tracker #(
   parameter int NUM_LINES  = DEF_NUM_LINES,
   parameter int LINE_WIDTH = $clog2(NUM_LINES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  hit,
   input  logic [LINE_WIDTH-1:0] hit_line,
   input  logic                  inv,
   input  logic [LINE_WIDTH-1:0] inv_line,
   input  logic                  flush,
   output logic [LINE_WIDTH-1:0] lru_line,
   output logic                  full
);

   access_e                       acc;
   logic [LINE_WIDTH-1:0]         touch_line;
   logic [LINE_WIDTH-1:0]         touch_age;
   logic [NUM_LINES*LINE_WIDTH-1:0] age_flat;
   logic [NUM_LINES-1:0]          valid;

   assign acc        = decode_access(en, hit);
   // A fill touches the victim shown before the edge.
   assign touch_line = (acc == ACC_HIT) ? hit_line : lru_line;
   assign touch_age  = age_flat[touch_line*LINE_WIDTH +: LINE_WIDTH];

   for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
      logic [LINE_WIDTH-1:0] age_r;
      logic                  valid_r;

      // Compare-and-increment: lines younger than the touched one age by one,
      // the touched line becomes youngest; older lines keep their rank.
      always_ff @(posedge clk) begin
         if (rst) begin
            age_r <= LINE_WIDTH'(g);
         end else if (acc != ACC_IDLE) begin
            if (touch_line == LINE_WIDTH'(g))
               age_r <= '0;
            else if (age_r < touch_age)
               age_r <= age_r + LINE_WIDTH'(1);
         end
      end

      // Valid bit: flush beats invalidate, which beats the fill setting it.
      always_ff @(posedge clk) begin
         if (rst)
            valid_r <= 1'b0;
         else if (flush)
            valid_r <= 1'b0;
         else if (inv && (inv_line == LINE_WIDTH'(g)))
            valid_r <= 1'b0;
         else if ((acc == ACC_FILL) && (lru_line == LINE_WIDTH'(g)))
            valid_r <= 1'b1;
      end

      assign age_flat[g*LINE_WIDTH +: LINE_WIDTH] = age_r;
      assign valid[g]                             = valid_r;
   end

   lru_victim_select #(
      .NUM_LINES  (NUM_LINES),
      .LINE_WIDTH (LINE_WIDTH)
   ) u_victim (
      .valid    (valid),
      .age_flat (age_flat),
      .lru_line (lru_line),
      .full     (full)
   );

`ifndef SYNTHESIS
   // Ages must stay pairwise distinct outside reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int a = 0; a < NUM_LINES; a++) begin
            for (int b = a + 1; b < NUM_LINES; b++) begin
               assert (age_flat[a*LINE_WIDTH +: LINE_WIDTH] != age_flat[b*LINE_WIDTH +: LINE_WIDTH])
                  else $error("lru_age_tracker: duplicate age on lines %0d and %0d", a, b);
            end
         end
      end
   end
`endif

endmodule
